leb128_encoder: RTL



---
 rtl/leb128_encoder_pkg.sv | 16 +
 rtl/leb128_encoder.sv | 89 ++++++++
 2 files changed

// File: rtl/leb128_encoder_pkg.sv
// Shared LEB128 definitions: stream state encoding, continuation-bit position
// and the per-width byte-count limit (also used by the CPU-side decoder).
package leb128_encoder_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } leb_state_t;

  localparam int LEB_CONT_BIT = 7;

  function automatic int leb128_max_bytes(input int width);
    return (width + 6) / 7;
  endfunction

endpackage

// File: rtl/leb128_encoder.sv
// Serialising LEB128 encoder: takes one WIDTH-bit value per handshake and emits
// its signed or unsigned LEB128 byte stream, one byte per cycle.
module leb128_encoder
  import leb128_encoder_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter bit SIGNED = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       out_byte,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic [3:0]       out_index
);

  localparam int MAX_BYTES = leb128_max_bytes(WIDTH);

  leb_state_t              state, state_nxt;
  logic signed [WIDTH-1:0] rem;
  logic signed [WIDTH-1:0] rem_sh;
  logic                    done;
  logic                    accept;
  logic                    fire;

  // Done detect and byte format, all from registered state.
  always_comb begin
    rem_sh = SIGNED ? (rem >>> 7) : (rem >> 7);
    if (SIGNED)
      done = ((rem_sh == '0) && !rem[6]) || ((rem_sh == '1) && rem[6]);
    else
      done = (rem_sh == '0);
    // Backstop: the width-derived byte limit always terminates the stream.
    if (out_index == 4'(MAX_BYTES - 1))
      done = 1'b1;
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  // Next state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_EMIT;
      ST_EMIT: if (fire && done && !accept) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs; out_ready -> in_ready is the only combinational path.
  always_comb begin
    out_valid = (state == ST_EMIT);
    out_last  = out_valid && done;
    out_byte  = '0;
    if (out_valid) begin
      out_byte[6:0]          = rem[6:0];
      out_byte[LEB_CONT_BIT] = ~done;
    end
    in_ready = reset && ((state == ST_IDLE) || (out_valid && done && out_ready));
  end

  assign accept = in_valid && in_ready;
  assign fire   = out_valid && out_ready;

  // Shift register and byte position
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem       <= '0;
      out_index <= '0;
    end else if (accept) begin
      rem       <= in_data;
      out_index <= '0;
    end else if (fire && !done) begin
      rem       <= rem_sh;
      out_index <= out_index + 4'd1;
    end
  end

endmodule
